// File: rtl/ddr_rd_xfer_scheduler.sv
// ddr_rd_xfer_scheduler: round-robin sharing of the DDR read master, splitting transfers into bounded chunks.
module ddr_rd_xfer_scheduler #(
    parameter int NUM_REQ            = 4,
    parameter int C_M_AXI_ADDR_WIDTH = 64,
    parameter int C_XFER_SIZE_WIDTH  = 32,
    parameter int MAX_CHUNK_BYTES    = 4096,
    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                                    clk,
    input  logic                                    reset,
    input  logic [NUM_REQ-1:0]                      req_valid,
    output logic [NUM_REQ-1:0]                      req_ready,
    input  logic [NUM_REQ*C_M_AXI_ADDR_WIDTH-1:0]   req_addr,
    input  logic [NUM_REQ*C_XFER_SIZE_WIDTH-1:0]    req_size,
    output logic [NUM_REQ-1:0]                      req_done,
    output logic                                    grant_valid,
    output logic [IW-1:0]                           grant_id,
    output logic                                    ap_start_rd,
    input  logic                                    ap_done_rd,
    output logic [C_M_AXI_ADDR_WIDTH-1:0]           ctrl_addr_offset_rd,
    output logic [C_XFER_SIZE_WIDTH-1:0]            ctrl_xfer_size_in_bytes_rd,
    output logic                                    busy
);
    localparam int AW = C_M_AXI_ADDR_WIDTH;
    localparam int SW = C_XFER_SIZE_WIDTH;
    localparam logic [SW-1:0] MAX_CHUNK = SW'(MAX_CHUNK_BYTES);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

    state_t        state, state_n;
    logic [IW-1:0] rr_ptr, id, g;
    logic          found, handshake, in_xfer;
    logic [AW-1:0] cur_addr, addr_g;
    logic [SW-1:0] remaining, chunk, size_g;
    int            idx;

    // First valid requester at or after rr_ptr, wrapping around.
    always_comb begin
        g = '0;
        found = 1'b0;
        idx = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = int'(rr_ptr) + k;
            idx = (idx >= NUM_REQ) ? idx - NUM_REQ : idx;
            g = (!found && req_valid[IW'(idx)]) ? IW'(idx) : g;
            found = found || req_valid[IW'(idx)];
        end
    end

    assign addr_g    = req_addr[g*AW +: AW];
    assign size_g    = req_size[g*SW +: SW];
    assign handshake = (state == IDLE) && found && !reset;
    assign chunk     = (remaining > MAX_CHUNK) ? MAX_CHUNK : remaining;

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE:  state_n = handshake ? ((size_g == '0) ? DONE : ISSUE) : IDLE;
            ISSUE: state_n = WAIT;
            WAIT:  state_n = ap_done_rd ? ((remaining == chunk) ? DONE : ISSUE) : WAIT;
            DONE:  state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            rr_ptr    <= '0;
            id        <= '0;
            cur_addr  <= '0;
            remaining <= '0;
        end else begin
            state <= state_n;
            if (handshake) begin
                cur_addr  <= addr_g;
                remaining <= size_g;
                id        <= g;
            end
            if (state == WAIT && ap_done_rd) begin
                cur_addr  <= cur_addr + AW'(chunk);
                remaining <= remaining - chunk;
            end
            if (state == DONE)
                rr_ptr <= (int'(id) == NUM_REQ - 1) ? '0 : id + 1'b1;
        end
    end

    assign in_xfer                    = (state == ISSUE) || (state == WAIT);
    assign req_ready                  = handshake ? (NUM_REQ'(1) << g) : '0;
    assign req_done                   = (state == DONE) ? (NUM_REQ'(1) << id) : '0;
    assign grant_valid                = (state != IDLE);
    assign grant_id                   = grant_valid ? id : '0;
    assign busy                       = grant_valid;
    assign ap_start_rd                = (state == ISSUE);
    assign ctrl_addr_offset_rd        = in_xfer ? cur_addr : '0;
    assign ctrl_xfer_size_in_bytes_rd = in_xfer ? chunk : '0;
endmodule

// File: tb/tb_ddr_rd_xfer_scheduler.sv
// tb_ddr_rd_xfer_scheduler: directed checks of arbitration, chunking, zero-size, reset and spurious-done handling.
module tb_ddr_rd_xfer_scheduler;
    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic [3:0]   req_valid = '0;
    logic [3:0]   req_ready;
    logic [255:0] req_addr = '0;
    logic [127:0] req_size = '0;
    logic [3:0]   req_done;
    logic         grant_valid;
    logic [1:0]   grant_id;
    logic         ap_start_rd;
    logic         ap_done_rd = 1'b0;
    logic [63:0]  ctrl_addr_offset_rd;
    logic [31:0]  ctrl_xfer_size_in_bytes_rd;
    logic         busy;
    int           n_tests = 0;
    int           n_fail = 0;

    ddr_rd_xfer_scheduler dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_addr(req_addr), .req_size(req_size), .req_done(req_done),
        .grant_valid(grant_valid), .grant_id(grant_id),
        .ap_start_rd(ap_start_rd), .ap_done_rd(ap_done_rd),
        .ctrl_addr_offset_rd(ctrl_addr_offset_rd),
        .ctrl_xfer_size_in_bytes_rd(ctrl_xfer_size_in_bytes_rd),
        .busy(busy)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout required finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h required 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_desc(input int r, input logic [63:0] a, input logic [31:0] s);
        req_addr[r*64 +: 64] = a;
        req_size[r*32 +: 32] = s;
    endtask

    task automatic wait_ready();
        int n = 0;
        while (req_ready == '0 && n < 20) begin
            tick();
            n++;
        end
    endtask

    task automatic request(input int r, input logic [63:0] a, input logic [31:0] s);
        set_desc(r, a, s);
        req_valid[r] = 1'b1;
        #1;
        wait_ready();
        check("ready", 64'(req_ready), 64'(4'b0001 << r));
        tick();
        req_valid[r] = 1'b0;
        #1;
    endtask

    task automatic chunk(input logic [63:0] a, input logic [31:0] s, input bit spur);
        check("start", 64'(ap_start_rd), 64'd1);
        check("addr", ctrl_addr_offset_rd, a);
        check("size", 64'(ctrl_xfer_size_in_bytes_rd), 64'(s));
        check("grant_valid", 64'(grant_valid), 64'd1);
        ap_done_rd = spur;
        tick();
        ap_done_rd = 1'b0;
        check("start_one_cycle", 64'(ap_start_rd), 64'd0);
        check("addr_hold", ctrl_addr_offset_rd, a);
        check("size_hold", 64'(ctrl_xfer_size_in_bytes_rd), 64'(s));
        tick();
        ap_done_rd = 1'b1;
        tick();
        ap_done_rd = 1'b0;
    endtask

    task automatic expect_done(input int r);
        check("done", 64'(req_done), 64'(4'b0001 << r));
        check("no_extra_start", 64'(ap_start_rd), 64'd0);
        tick();
        check("done_one_cycle", 64'(req_done), 64'd0);
        check("idle", 64'(busy), 64'd0);
    endtask

    int order [9] = '{0, 1, 2, 3, 0, 1, 3, 1, 3};

    initial begin
        tick();
        tick();
        check("rst_ready", 64'(req_ready), 64'd0);
        check("rst_done", 64'(req_done), 64'd0);
        check("rst_grant", 64'({grant_valid, grant_id}), 64'd0);
        check("rst_start", 64'(ap_start_rd), 64'd0);
        check("rst_addr", ctrl_addr_offset_rd, 64'd0);
        check("rst_size", 64'(ctrl_xfer_size_in_bytes_rd), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        reset = 1'b0;
        tick();

        // single 10000-byte transfer
        request(0, 64'h1000_0000, 32'd10000);
        chunk(64'h1000_0000, 32'd4096, 1'b0);
        chunk(64'h1000_1000, 32'd4096, 1'b0);
        chunk(64'h1000_2000, 32'd1808, 1'b0);
        expect_done(0);

        // exact multiple: two chunks only
        request(0, 64'h2000_0000, 32'd8192);
        chunk(64'h2000_0000, 32'd4096, 1'b0);
        chunk(64'h2000_1000, 32'd4096, 1'b0);
        expect_done(0);

        // reset mid-WAIT with coincident ap_done_rd
        request(0, 64'h1000_0000, 32'd10000);
        check("rw_start", 64'(ap_start_rd), 64'd1);
        tick();
        reset = 1'b1;
        ap_done_rd = 1'b1;
        tick();
        ap_done_rd = 1'b0;
        check("rw_busy", 64'(busy), 64'd0);
        check("rw_grant", 64'({grant_valid, grant_id}), 64'd0);
        check("rw_start0", 64'(ap_start_rd), 64'd0);
        check("rw_addr", ctrl_addr_offset_rd, 64'd0);
        check("rw_size", 64'(ctrl_xfer_size_in_bytes_rd), 64'd0);
        check("rw_done", 64'(req_done), 64'd0);
        reset = 1'b0;
        tick();
        check("rw_no_done", 64'(req_done), 64'd0);
        set_desc(0, 64'h40, 32'd64);
        set_desc(1, 64'h80, 32'd64);
        req_valid = 4'b0011;
        #1;
        check("rw_ptr0", 64'(req_ready), 64'd1);
        tick();
        req_valid = '0;
        chunk(64'h40, 32'd64, 1'b0);
        expect_done(0);

        // round robin: all four valid, then only 1 and 3
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();
        for (int r = 0; r < 4; r++) set_desc(r, 64'h100 * (r + 1), 32'd64);
        for (int i = 0; i < 9; i++) begin
            req_valid = (i < 5) ? 4'b1111 : 4'b1010;
            #1;
            wait_ready();
            check("rr_ready", 64'(req_ready), 64'(4'b0001 << order[i]));
            tick();
            if (i == 8) req_valid = '0;
            check("rr_id", 64'(grant_id), 64'(order[i]));
            chunk(64'h100 * (order[i] + 1), 32'd64, 1'b0);
            expect_done(order[i]);
        end

        // zero-size: done without any DDR command
        request(2, 64'h3000, 32'd0);
        check("zero_start", 64'(ap_start_rd), 64'd0);
        check("zero_done", 64'(req_done), 64'b0100);
        tick();
        check("zero_done_clr", 64'(req_done), 64'd0);
        check("zero_start2", 64'(ap_start_rd), 64'd0);
        check("zero_idle", 64'(busy), 64'd0);

        // address wraps modulo 2^64, odd size passed through
        request(1, 64'hFFFF_FFFF_FFFF_F800, 32'd6000);
        chunk(64'hFFFF_FFFF_FFFF_F800, 32'd4096, 1'b0);
        chunk(64'h800, 32'd1904, 1'b0);
        expect_done(1);

        // spurious ap_done_rd in IDLE and ISSUE
        ap_done_rd = 1'b1;
        tick();
        ap_done_rd = 1'b0;
        check("spur_idle", 64'(busy), 64'd0);
        request(0, 64'h1000_0000, 32'd10000);
        chunk(64'h1000_0000, 32'd4096, 1'b1);
        chunk(64'h1000_1000, 32'd4096, 1'b1);
        chunk(64'h1000_2000, 32'd1808, 1'b1);
        expect_done(0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
